// File: rtl/m_mc_ctrl.sv
// m_mc_ctrl: multi-cycle sequencing controller for the RV32I datapath.
// It steps each instruction through IF/ID/EX/MEM/WB. It drives the datapath
// write and read enables, waits on the memory ready handshakes, and supports
// a debug halt. It traps illegal opcodes and counts cycles and retired
// instructions.
//
// Ports:
//   w_clk, w_rst       clock; synchronous active-high reset
//   w_op               opcode field ir[6:0], valid from ID onward
//   w_imem_rdy         instruction memory data valid this cycle
//   w_dmem_rdy         data memory access complete this cycle
//   w_halt             debug halt request
//   r_state            FSM state (IF=0 ID=1 EX=2 MEM=3 WB=4 HALT=5)
//   w_imem_re/w_ir_we  fetch request / instruction register load
//   w_pc_we            next-PC load, high only in the retire cycle
//   w_rf_we            register file write enable
//   w_dmem_re/we       data memory read / write request
//   r_illegal          sticky illegal-opcode flag
//   r_cycle            count of non-HALT cycles
//   r_retired          count of retired instructions
module m_mc_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             w_clk,
    input  logic             w_rst,
    input  logic [6:0]       w_op,
    input  logic             w_imem_rdy,
    input  logic             w_dmem_rdy,
    input  logic             w_halt,
    output logic [2:0]       r_state,
    output logic             w_imem_re,
    output logic             w_ir_we,
    output logic             w_pc_we,
    output logic             w_rf_we,
    output logic             w_dmem_re,
    output logic             w_dmem_we,
    output logic             r_illegal,
    output logic [CNT_W-1:0] r_cycle,
    output logic [CNT_W-1:0] r_retired
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    state_t state_q;
    logic   is_alu, is_load, is_store, is_branch;
    logic   retire_c;

    assign r_state   = state_q;
    assign is_alu    = (w_op == OP_ALU_R) || (w_op == OP_ALU_I);
    assign is_load   = (w_op == OP_LOAD);
    assign is_store  = (w_op == OP_STORE);
    assign is_branch = (w_op == OP_BRANCH);

    // Enable decode; reset suppresses everything in the same cycle so an
    // abandoned instruction never writes PC, RF or memory.
    always_comb begin
        w_imem_re = 1'b0;
        w_ir_we   = 1'b0;
        w_rf_we   = 1'b0;
        w_dmem_re = 1'b0;
        w_dmem_we = 1'b0;
        retire_c  = 1'b0;
        if (!w_rst) begin
            case (state_q)
                S_IF: begin
                    w_imem_re = 1'b1;
                    w_ir_we   = w_imem_rdy;
                end
                S_EX: retire_c = is_branch;
                S_MEM: begin
                    w_dmem_re = is_load;
                    w_dmem_we = is_store;
                    retire_c  = is_store && w_dmem_rdy;
                end
                S_WB: begin
                    w_rf_we  = 1'b1;
                    retire_c = 1'b1;
                end
                default: ;
            endcase
        end
        w_pc_we = retire_c;
    end

    // State register, sticky illegal flag and counters.
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q   <= S_IF;
            r_illegal <= 1'b0;
            r_cycle   <= '0;
            r_retired <= '0;
        end else begin
            if (state_q != S_HALT) r_cycle <= r_cycle + CNT_W'(1);
            if (retire_c)          r_retired <= r_retired + CNT_W'(1);
            case (state_q)
                S_IF: begin
                    // A completing fetch wins over a simultaneous halt.
                    if (w_imem_rdy)  state_q <= S_ID;
                    else if (w_halt) state_q <= S_HALT;
                end
                S_ID: begin
                    if (is_alu || is_load || is_store || is_branch) begin
                        state_q <= S_EX;
                    end else begin
                        r_illegal <= 1'b1;
                        state_q   <= S_HALT;
                    end
                end
                S_EX: begin
                    if (is_load || is_store) state_q <= S_MEM;
                    else if (is_alu)         state_q <= S_WB;
                    else if (!is_branch) begin
                        r_illegal <= 1'b1;
                        state_q   <= S_HALT;
                    end
                end
                S_MEM: begin
                    if (w_dmem_rdy && is_load) state_q <= S_WB;
                    else if (!is_load && !is_store) begin
                        r_illegal <= 1'b1;
                        state_q   <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (!r_illegal && !w_halt) state_q <= S_IF;
                end
                default: state_q <= S_IF;
            endcase
            // Retire cycle: return to fetch, or park if a halt is pending.
            if (retire_c) state_q <= w_halt ? S_HALT : S_IF;
        end
    end

endmodule

// File: tb/tb_m_mc_ctrl.sv
module tb_m_mc_ctrl;
    localparam int unsigned CNT_W = 32;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic             w_clk = 1'b0;
    logic             w_rst, w_imem_rdy, w_dmem_rdy, w_halt;
    logic [6:0]       w_op;
    logic [2:0]       r_state;
    logic             w_imem_re, w_ir_we, w_pc_we, w_rf_we, w_dmem_re, w_dmem_we;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cycle, r_retired;

    int passed = 0;
    int total  = 0;

    m_mc_ctrl #(.CNT_W(CNT_W)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .w_op(w_op),
        .w_imem_rdy(w_imem_rdy), .w_dmem_rdy(w_dmem_rdy), .w_halt(w_halt),
        .r_state(r_state), .w_imem_re(w_imem_re), .w_ir_we(w_ir_we),
        .w_pc_we(w_pc_we), .w_rf_we(w_rf_we), .w_dmem_re(w_dmem_re),
        .w_dmem_we(w_dmem_we), .r_illegal(r_illegal),
        .r_cycle(r_cycle), .r_retired(r_retired)
    );

    always #5 w_clk = ~w_clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    // One reset cycle; inputs are otherwise left idle.
    task automatic do_reset();
        w_rst = 1'b1; w_halt = 1'b0; w_imem_rdy = 1'b1; w_dmem_rdy = 1'b1;
        tick();
        w_rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] en;
        w_rst = 1'b1; w_op = OP_ALU_R; w_halt = 1'b0;
        w_imem_rdy = 1'b1; w_dmem_rdy = 1'b1;
        #1;
        en = {w_imem_re, w_ir_we, w_pc_we, w_rf_we, w_dmem_re, w_dmem_we};
        total++; if (en !== 6'b0) $display("FAIL reset_enables got %b want 000000", en); else passed++;
        tick();
        w_rst = 1'b0;
        #1;
        total++; if (r_state !== 3'd0) $display("FAIL reset_state got %0d want 0", r_state); else passed++;
        total++; if (r_illegal !== 1'b0) $display("FAIL reset_illegal got %b want 0", r_illegal); else passed++;
        total++; if (r_cycle !== 0) $display("FAIL reset_cycle got %0d want 0", r_cycle); else passed++;
        total++; if (r_retired !== 0) $display("FAIL reset_retired got %0d want 0", r_retired); else passed++;
    endtask

    task automatic test_alu_r();
        logic [2:0] seq [4];
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd4;
        do_reset();
        w_op = OP_ALU_R;
        #1;
        for (int i = 0; i < 12; i++) begin
            total++; if (r_state !== seq[i%4]) $display("FAIL alu_state[%0d] got %0d want %0d", i, r_state, seq[i%4]); else passed++;
            total++; if (w_pc_we !== (i%4 == 3)) $display("FAIL alu_pc_we[%0d] got %b want %b", i, w_pc_we, (i%4 == 3)); else passed++;
            total++; if (w_rf_we !== (i%4 == 3)) $display("FAIL alu_rf_we[%0d] got %b want %b", i, w_rf_we, (i%4 == 3)); else passed++;
            total++; if (w_ir_we !== (i%4 == 0)) $display("FAIL alu_ir_we[%0d] got %b want %b", i, w_ir_we, (i%4 == 0)); else passed++;
            tick();
        end
        total++; if (r_retired !== 3) $display("FAIL alu_retired got %0d want 3", r_retired); else passed++;
        total++; if (r_cycle !== 12) $display("FAIL alu_cycle got %0d want 12", r_cycle); else passed++;
    endtask

    task automatic test_load();
        logic [2:0] seq [8];
        int rf_cnt = 0;
        int pc_cnt = 0;
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3;
        seq[4] = 3'd3; seq[5] = 3'd3; seq[6] = 3'd3; seq[7] = 3'd4;
        do_reset();
        w_op = OP_LOAD;
        for (int i = 0; i < 8; i++) begin
            w_dmem_rdy = (i == 6);
            #1;
            total++; if (r_state !== seq[i]) $display("FAIL load_state[%0d] got %0d want %0d", i, r_state, seq[i]); else passed++;
            total++; if (w_dmem_re !== (seq[i] == 3'd3)) $display("FAIL load_dmem_re[%0d] got %b want %b", i, w_dmem_re, (seq[i] == 3'd3)); else passed++;
            if (w_rf_we) rf_cnt++;
            if (w_pc_we) pc_cnt++;
            tick();
        end
        total++; if (rf_cnt != 1) $display("FAIL load_rf_pulses got %0d want 1", rf_cnt); else passed++;
        total++; if (pc_cnt != 1) $display("FAIL load_pc_pulses got %0d want 1", pc_cnt); else passed++;
        total++; if (r_state !== 3'd0) $display("FAIL load_end_state got %0d want 0", r_state); else passed++;
        total++; if (r_cycle !== 8) $display("FAIL load_cycle got %0d want 8", r_cycle); else passed++;
    endtask

    task automatic test_store_branch();
        logic [2:0] seq [7];
        seq[0] = 3'd0; seq[1] = 3'd1; seq[2] = 3'd2; seq[3] = 3'd3;
        seq[4] = 3'd0; seq[5] = 3'd1; seq[6] = 3'd2;
        do_reset();
        for (int i = 0; i < 7; i++) begin
            w_op = (i < 4) ? OP_STORE : OP_BRANCH;
            #1;
            total++; if (r_state !== seq[i]) $display("FAIL sb_state[%0d] got %0d want %0d", i, r_state, seq[i]); else passed++;
            total++; if (w_pc_we !== (i == 3 || i == 6)) $display("FAIL sb_pc_we[%0d] got %b want %b", i, w_pc_we, (i == 3 || i == 6)); else passed++;
            total++; if (w_rf_we !== 1'b0) $display("FAIL sb_rf_we[%0d] got %b want 0", i, w_rf_we); else passed++;
            total++; if (w_dmem_we !== (i == 3)) $display("FAIL sb_dmem_we[%0d] got %b want %b", i, w_dmem_we, (i == 3)); else passed++;
            tick();
        end
        total++; if (r_retired !== 2) $display("FAIL sb_retired got %0d want 2", r_retired); else passed++;
    endtask

    task automatic test_illegal();
        do_reset();
        w_op = 7'b1111111; w_halt = 1'b1;
        tick(); tick();
        total++; if (r_state !== 3'd5) $display("FAIL ill_state got %0d want 5", r_state); else passed++;
        total++; if (r_illegal !== 1'b1) $display("FAIL ill_flag got %b want 1", r_illegal); else passed++;
        w_halt = 1'b0;
        tick(); tick(); tick();
        total++; if (r_state !== 3'd5) $display("FAIL ill_stuck got %0d want 5", r_state); else passed++;
        total++; if (r_cycle !== 2) $display("FAIL ill_cycle_frozen got %0d want 2", r_cycle); else passed++;
        total++; if (w_imem_re !== 1'b0) $display("FAIL ill_imem_re got %b want 0", w_imem_re); else passed++;
        do_reset();
        total++; if (r_state !== 3'd0) $display("FAIL ill_rst_state got %0d want 0", r_state); else passed++;
        total++; if (r_illegal !== 1'b0) $display("FAIL ill_rst_flag got %b want 0", r_illegal); else passed++;
        total++; if (r_cycle !== 0 || r_retired !== 0) $display("FAIL ill_rst_counters got %0d/%0d want 0/0", r_cycle, r_retired); else passed++;
    endtask

    task automatic test_halt();
        do_reset();
        w_op = OP_ALU_I;
        tick(); tick();
        w_halt = 1'b1;               // raised in EX
        #1;
        total++; if (r_state !== 3'd2) $display("FAIL halt_ex_state got %0d want 2", r_state); else passed++;
        tick();
        total++; if (r_state !== 3'd4) $display("FAIL halt_wb_state got %0d want 4", r_state); else passed++;
        total++; if (w_rf_we !== 1'b1 || w_pc_we !== 1'b1) $display("FAIL halt_wb_en got %b%b want 11", w_rf_we, w_pc_we); else passed++;
        tick();
        total++; if (r_state !== 3'd5) $display("FAIL halt_state got %0d want 5", r_state); else passed++;
        total++; if (r_retired !== 1) $display("FAIL halt_retired got %0d want 1", r_retired); else passed++;
        tick();
        total++; if (r_state !== 3'd5 || r_cycle !== 4) $display("FAIL halt_hold got %0d/%0d want 5/4", r_state, r_cycle); else passed++;
        w_halt = 1'b0;
        tick();
        total++; if (r_state !== 3'd0) $display("FAIL halt_release got %0d want 0", r_state); else passed++;
        // Halt during a stalled fetch parks without loading IR.
        w_imem_rdy = 1'b0; w_halt = 1'b1;
        #1;
        total++; if (w_imem_re !== 1'b1 || w_ir_we !== 1'b0) $display("FAIL halt_if_en got %b%b want 10", w_imem_re, w_ir_we); else passed++;
        tick();
        total++; if (r_state !== 3'd5) $display("FAIL halt_if_state got %0d want 5", r_state); else passed++;
        w_halt = 1'b0;
        tick();
        // Halt and ready together: the fetch completes.
        w_imem_rdy = 1'b1; w_halt = 1'b1;
        tick();
        total++; if (r_state !== 3'd1) $display("FAIL halt_if_rdy got %0d want 1", r_state); else passed++;
        w_halt = 1'b0;
    endtask

    task automatic test_reset_mem();
        do_reset();
        w_op = OP_STORE; w_dmem_rdy = 1'b0;
        tick(); tick(); tick(); tick();
        total++; if (r_state !== 3'd3 || w_dmem_we !== 1'b1) $display("FAIL rmem_wait got %0d/%b want 3/1", r_state, w_dmem_we); else passed++;
        w_rst = 1'b1; w_dmem_rdy = 1'b1;
        #1;
        total++; if (w_dmem_we !== 1'b0 || w_pc_we !== 1'b0) $display("FAIL rmem_en got %b%b want 00", w_dmem_we, w_pc_we); else passed++;
        tick();
        w_rst = 1'b0;
        #1;
        total++; if (r_state !== 3'd0 || r_retired !== 0) $display("FAIL rmem_after got %0d/%0d want 0/0", r_state, r_retired); else passed++;
    endtask

    initial begin
        test_reset();
        test_alu_r();
        test_load();
        test_store_branch();
        test_illegal();
        test_halt();
        test_reset_mem();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end
endmodule

// File: doc/m_mc_ctrl.md
# m_mc_ctrl

Multi-cycle sequencing controller for the RV32I processor datapath: program counter, instruction memory, register file and ALU adder. It breaks each instruction into fetch, decode, execute, memory and writeback steps. It drives the write/read enables that the single-cycle datapath currently ties high, and it waits on ready handshakes from instruction and data memory. It also supports a debug halt, traps illegal opcodes, and keeps cycle and retired-instruction counters.

## Interface

Parameters:
- CNT_W, 32: width of the cycle and retired-instruction counters.

Ports:
- w_clk  in  1  clock; all state updates on posedge.
- w_rst  in  1  synchronous, active-high reset.
- w_op  in  7  opcode field ir[6:0] from the instruction register; valid from ID onward.
- w_imem_rdy  in  1  instruction memory has data this cycle.
- w_dmem_rdy  in  1  data memory has completed the access this cycle.
- w_halt  in  1  debug halt request.
- r_state  out  3  FSM state: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- w_imem_re  out  1  instruction fetch request.
- w_ir_we  out  1  instruction register load.
- w_pc_we  out  1  PC <= next-PC load; asserted exactly in the retire cycle.
- w_rf_we  out  1  register file write enable.
- w_dmem_re  out  1  data memory read request.
- w_dmem_we  out  1  data memory write request.
- r_illegal  out  1  sticky illegal-opcode flag.
- r_cycle  out  CNT_W  count of non-HALT cycles.
- r_retired  out  CNT_W  count of retired instructions.

## Operation

Decoded classes (from w_op):
- ALU-R: 0110011.
- ALU-I: 0010011.
- LOAD: 0000011.
- STORE: 0100011.
- BRANCH: 1100011.
- Any other value is illegal.

State behaviour and transitions:
- IF: w_imem_re=1.
  - w_imem_rdy=0: stay in IF.
  - w_imem_rdy=1: w_ir_we=1, go to ID.
  - w_halt=1 while w_imem_rdy=0: go to HALT, no IR load.
  - w_halt=1 and w_imem_rdy=1 in the same cycle: the fetch completes and goes to ID.
- ID: no enables. Illegal opcode: r_illegal<=1, go to HALT. Otherwise go to EX.
- EX: no enables except for BRANCH.
  - LOAD or STORE: go to MEM.
  - ALU-R or ALU-I: go to WB.
  - BRANCH: retire.
- MEM:
  - LOAD: w_dmem_re=1. STORE: w_dmem_we=1.
  - Hold the request and stay in MEM while w_dmem_rdy=0.
  - On w_dmem_rdy=1: LOAD goes to WB; STORE retires.
- WB: w_rf_we=1, then retire.
- Retire cycle: w_pc_we=1 and r_retired increments. The next state is IF, or HALT if w_halt=1 in that cycle.
- HALT:
  - All enables are 0.
  - If r_illegal=1: stay in HALT until reset.
  - Otherwise: stay while w_halt=1, and go to IF on the first cycle w_halt=0.

Counters:
- r_cycle increments every cycle where r_state!=HALT and w_rst=0.
- Both counters wrap modulo 2^CNT_W with no saturation.

Output decoding:
- Enables are combinational from r_state, w_op and the ready inputs.
- w_rst=1 forces every enable to 0 in that same cycle.

## Timing

Reset:
- w_rst sampled high sets r_state=IF, r_illegal=0, r_cycle=0, r_retired=0.
- All enables read 0 during the reset cycle.
- Reset mid-instruction (any state, including a MEM wait) abandons the instruction with no PC, RF or memory write.

Latency with ready inputs tied high:
- ALU-R or ALU-I: 4 cycles (IF, ID, EX, WB).
- LOAD: 5 cycles (IF, ID, EX, MEM, WB).
- STORE: 4 cycles (IF, ID, EX, MEM).
- BRANCH: 3 cycles (IF, ID, EX).
- Each cycle of ready low adds exactly one cycle.

Handshakes:
- A request (w_imem_re, w_dmem_re, w_dmem_we) stays asserted from state entry until the cycle in which its ready is sampled high, inclusive.
- At most one memory request is asserted in any cycle.

Pulse widths:
- w_pc_we is asserted exactly once per retired instruction.
- w_ir_we is asserted exactly once per fetch.

Halt timing:
- w_halt rising in the middle of an instruction takes effect only in the retire cycle.
- The instruction in flight always completes.

## Test plan

- Reset, then ALU-R opcode with both ready inputs high: states 0,1,2,4 repeat. w_pc_we is high every 4th cycle, with w_rf_we high in the same cycle. After 12 cycles, r_retired=3 and r_cycle=12.
- LOAD with w_dmem_rdy low for 3 cycles: MEM lasts 4 cycles with w_dmem_re held high. Total latency is 8 cycles, one w_rf_we pulse and one w_pc_we pulse.
- STORE, then BRANCH: the STORE retires at cycle 4 with no w_rf_we; the BRANCH retires 3 cycles later; r_retired=2.
- Opcode 1111111 decoded in ID: r_illegal=1 and state HALT. Deasserting w_halt does not leave HALT, and r_cycle freezes. Applying w_rst returns to IF with the counters cleared.
- w_halt raised during EX of an ALU-I: WB still writes and retires, then HALT. Lowering w_halt gives IF on the next cycle.
- Assert w_rst during a MEM wait of a STORE: w_dmem_we and w_pc_we are 0 in the reset cycle, and the state is IF afterwards.
